// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//
// Parametrised serial pattern detector. The block watches the serial bit `w`,
// qualified by `en`. It pulses `z` for one cycle whenever the last N accepted
// bits equal the pattern register. The pattern can be reloaded at run time.
// Matching is overlapping or non-overlapping, chosen per accepted cycle by
// `overlap`. A saturating counter records how many matches have occurred.
//
// Parameters
//   N        pattern length in bits (N >= 2)
//   PATTERN  pattern loaded by Reset; the MSB is the oldest bit
//   CNT_W    width of the match counter
//
// Ports
//   Clock        in   rising-edge clock for all state
//   Reset        in   synchronous active-high reset
//   en           in   accept `w` this cycle
//   w            in   serial data bit
//   overlap      in   1 = overlapping matches, 0 = non-overlapping
//   load         in   load `pattern_in`; clears the history and the fill count
//   pattern_in   in   new pattern (MSB oldest)
//   clear_count  in   zero the match counter (wins over a same-cycle match)
//   z            out  registered one-cycle match pulse
//   match_count  out  saturating match count
//   pattern      out  current pattern register
// -----------------------------------------------------------------------------
module seq_detector_param #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = N'(4'b1101),
    parameter int             CNT_W   = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             en,
    input  logic             w,
    input  logic             overlap,
    input  logic             load,
    input  logic [N-1:0]     pattern_in,
    input  logic             clear_count,
    output logic             z,
    output logic [CNT_W-1:0] match_count,
    output logic [N-1:0]     pattern
);

    localparam int                 FILL_W    = $clog2(N + 1);
    localparam logic [FILL_W-1:0]  FILL_ZERO = FILL_W'(0);
    localparam logic [FILL_W-1:0]  FILL_ONE  = FILL_W'(1);
    localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(N);
    localparam logic [CNT_W-1:0]   CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [N-1:0]       HIST_ZERO = N'(0);

    // State registers
    logic [N-1:0]      hist_r;   // last accepted bits, LSB newest
    logic [FILL_W-1:0] fill_r;   // accepted bits counted towards the next match
    logic [N-1:0]      pat_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              z_r;

    // Next-state helpers
    logic              accept_s;
    logic [N-1:0]      hist_next_s;
    logic [FILL_W-1:0] fill_inc_s;
    logic [FILL_W-1:0] fill_next_s;
    logic              match_s;
    logic [CNT_W-1:0]  cnt_next_s;

    // Datapath for one accepted bit: shifted history, saturated fill, match decision
    always_comb begin
        accept_s    = en & ~load;
        hist_next_s = {hist_r[N-2:0], w};

        // The fill count stops at N. A full history stays "full" while
        // overlapping matching is active.
        if (fill_r == FILL_FULL) begin
            fill_inc_s = FILL_FULL;
        end else begin
            fill_inc_s = fill_r + FILL_ONE;
        end

        // Comparing the whole shift register against the pattern catches
        // every occurrence for any input history. A mismatch never forces
        // the history back to idle.
        match_s = accept_s && (fill_inc_s == FILL_FULL) && (hist_next_s == pat_r);

        // A non-overlapping match makes the history unusable for the next
        // match. An overlapping match keeps it, so the pattern's suffix can
        // start the next match.
        if (match_s) begin
            if (overlap) begin
                fill_next_s = FILL_FULL;
            end else begin
                fill_next_s = FILL_ZERO;
            end
        end else begin
            fill_next_s = fill_inc_s;
        end
    end

    // Next match count: clear wins over a same-cycle match, and the count saturates at all-ones
    always_comb begin
        if (clear_count) begin
            cnt_next_s = CNT_ZERO;
        end else if (match_s && (cnt_r != CNT_MAX)) begin
            cnt_next_s = cnt_r + CNT_ONE;
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Pattern, history, fill and match-pulse registers; load takes priority over en
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pat_r  <= PATTERN;
            hist_r <= HIST_ZERO;
            fill_r <= FILL_ZERO;
            z_r    <= 1'b0;
        end else if (load) begin
            pat_r  <= pattern_in;
            hist_r <= HIST_ZERO;
            fill_r <= FILL_ZERO;
            z_r    <= 1'b0;
        end else if (en) begin
            pat_r  <= pat_r;
            hist_r <= hist_next_s;
            fill_r <= fill_next_s;
            z_r    <= match_s;
        end else begin
            pat_r  <= pat_r;
            hist_r <= hist_r;
            fill_r <= fill_r;
            z_r    <= 1'b0;
        end
    end

    // Match counter register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

    assign z           = z_r;
    assign match_count = cnt_r;
    assign pattern     = pat_r;

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// Testbench for seq_detector_param.
// There are two instances: A uses the defaults (N=4, pattern 1101, CNT_W=8);
// B uses N=2, pattern 11, CNT_W=2. Both share the same stimulus.
// Each issued cycle pushes the reference model's expected outputs into a
// queue. A monitor pops one entry per clock, just after the edge, and
// compares it with the outputs of both instances.
// The reference model treats the input as a number built from the accepted
// bits. It also keeps a count of bits accepted since the last restart.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       en = 1'b0;
    logic       w = 1'b0;
    logic       overlap = 1'b0;
    logic       load = 1'b0;
    logic       clear_count = 1'b0;
    logic [3:0] pattern_in_a = 4'd0;
    logic [1:0] pattern_in_b = 2'd0;

    logic       z_a;
    logic [7:0] match_count_a;
    logic [3:0] pattern_a;
    logic       z_b;
    logic [1:0] match_count_b;
    logic [1:0] pattern_b;

    seq_detector_param dut_a (
        .Clock       (Clock),
        .Reset       (Reset),
        .en          (en),
        .w           (w),
        .overlap     (overlap),
        .load        (load),
        .pattern_in  (pattern_in_a),
        .clear_count (clear_count),
        .z           (z_a),
        .match_count (match_count_a),
        .pattern     (pattern_a)
    );

    seq_detector_param #(.N(2), .PATTERN(2'b11), .CNT_W(2)) dut_b (
        .Clock       (Clock),
        .Reset       (Reset),
        .en          (en),
        .w           (w),
        .overlap     (overlap),
        .load        (load),
        .pattern_in  (pattern_in_b),
        .clear_count (clear_count),
        .z           (z_b),
        .match_count (match_count_b),
        .pattern     (pattern_b)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int z_a;
        int cnt_a;
        int pat_a;
        int z_b;
        int cnt_b;
        int pat_b;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state for instance 0 (A) and instance 1 (B)
    int nn[2]   = '{4, 2};
    int cmax[2] = '{255, 3};
    int pat0[2] = '{13, 3};
    int pat_m[2];
    int bits_m[2];   // accepted bits as a number, newest bit = LSB
    int run_m[2];    // bits accepted since reset / load / non-overlapping match
    int cnt_m[2];
    int z_m[2];

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: one expected entry per issued cycle, sampled after the edge
    always @(posedge Clock) begin
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            e_mon = exp_q.pop_front();
            check("z_a",     32'(z_a),           e_mon.z_a);
            check("count_a", 32'(match_count_a), e_mon.cnt_a);
            check("pat_a",   32'(pattern_a),     e_mon.pat_a);
            check("z_b",     32'(z_b),           e_mon.z_b);
            check("count_b", 32'(match_count_b), e_mon.cnt_b);
            check("pat_b",   32'(pattern_b),     e_mon.pat_b);
        end
    end

    // Drive one cycle of stimulus and push the model's expected outputs
    task automatic step(input bit r, input bit e, input bit wi, input bit ov,
                        input bit ld, input int pin, input bit clr);
        exp_t ex;
        int   match;
        @(negedge Clock);
        Reset        = r;
        en           = e;
        w            = wi;
        overlap      = ov;
        load         = ld;
        clear_count  = clr;
        pattern_in_a = pin[3:0];
        pattern_in_b = pin[1:0];
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                pat_m[i] = pat0[i]; bits_m[i] = 0; run_m[i] = 0; z_m[i] = 0; cnt_m[i] = 0;
            end else if (ld) begin
                pat_m[i] = pin % (1 << nn[i]); bits_m[i] = 0; run_m[i] = 0; z_m[i] = 0;
                if (clr) cnt_m[i] = 0;
            end else if (e) begin
                bits_m[i] = (bits_m[i] * 2 + int'(wi)) % 65536;
                run_m[i]  = run_m[i] + 1;
                match = (run_m[i] >= nn[i]) && ((bits_m[i] % (1 << nn[i])) == pat_m[i]);
                z_m[i] = match;
                if (match && !ov) run_m[i] = 0;
                if (clr) cnt_m[i] = 0;
                else if (match && cnt_m[i] < cmax[i]) cnt_m[i] = cnt_m[i] + 1;
            end else begin
                z_m[i] = 0;
                if (clr) cnt_m[i] = 0;
            end
        end
        ex.z_a = z_m[0]; ex.cnt_a = cnt_m[0]; ex.pat_a = pat_m[0];
        ex.z_b = z_m[1]; ex.cnt_b = cnt_m[1]; ex.pat_b = pat_m[1];
        exp_q.push_back(ex);
    endtask

    task automatic bits_in(input int value, input int len, input bit ov);
        for (int k = len - 1; k >= 0; k--) begin
            step(1'b0, 1'b1, value[k], ov, 1'b0, 0, 1'b0);
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        do_reset();
        do_reset();

        // 1101 non-overlapping
        bits_in(4'b1101, 4, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // 1101101 overlapping, then non-overlapping
        do_reset();
        bits_in(7'b1101101, 7, 1'b1);
        do_reset();
        bits_in(7'b1101101, 7, 1'b0);

        // 11101, then the same stream with an en gap between bits 3 and 4
        do_reset();
        bits_in(5'b11101, 5, 1'b0);
        do_reset();
        bits_in(3'b111, 3, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        bits_in(2'b01, 2, 1'b0);

        // load 0110 mid-stream; the w bit in the load cycle is discarded
        do_reset();
        bits_in(3'b101, 3, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6, 1'b0);
        bits_in(4'b0110, 4, 1'b0);

        // w held high with overlap: B (pattern 11, 2-bit counter) saturates,
        // then clear_count lands on a B match
        do_reset();
        bits_in(6'b111111, 6, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);

        // reset mid-stream discards the partial history
        do_reset();
        bits_in(3'b110, 3, 1'b0);
        do_reset();
        bits_in(1'b1, 1, 1'b0);
        do_reset();
        bits_in(4'b1101, 4, 1'b0);

        // A saturates at 255 with pattern 1111, then is cleared
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 15, 1'b0);
        repeat (262) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1);

        // randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 59) == 0,
                 int'($urandom_range(0, 15)),
                 $urandom_range(0, 49) == 0);
        end

        // drain the scoreboard with a bounded wait
        repeat (2) @(negedge Clock);
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge Clock);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain actual=%0d required=0 entries left", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
